// File: rtl/data_ctrl.sv
// Frame buffer / reorder unit: loads N=2**LOG2N samples, then drains them to the FFT core.
// Build macro DATACTRL_BITREV_EN selects bit-reversed drain order; natural order otherwise.
module data_ctrl #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W:0]   i_data,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic [LOG2N-1:0]  index,
  output logic [LOG2N-1:0]  indexNext
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_PREFETCH,
    S_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [LOG2N-1:0]    r_index;
  logic [LOG2N-1:0]    w_index_next;
  logic                r_valid;
  logic                w_valid_next;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_mem [N];
  logic                w_accept;
  logic                w_wr_en;
  logic [LOG2N-1:0]    w_wr_addr;
  logic                w_rd_en;
  logic [LOG2N-1:0]    w_rd_addr;

  function automatic logic [LOG2N-1:0] f_addr(input logic [LOG2N-1:0] k);
`ifdef DATACTRL_BITREV_EN
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = k[LOG2N-1-b];
    return r;
`else
    return k;
`endif
  endfunction

  assign o_data_ready = (r_state == S_LOAD) & ~i_rst;
  assign w_accept     = i_data_valid & o_data_ready;

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_valid_next = r_valid;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_index;
    w_rd_en      = 1'b0;
    w_rd_addr    = f_addr(r_index);
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          // frame-start flag resyncs the write pointer, even at the last slot
          if (i_data[DATA_W]) begin
            w_wr_addr    = '0;
            w_index_next = ONE;
          end else begin
            w_index_next = r_index + 1'b1;
            if (r_index == LAST) w_state_next = S_PREFETCH;
          end
        end
      end
      S_PREFETCH: begin
        w_rd_en      = 1'b1;
        w_rd_addr    = f_addr('0);
        w_valid_next = 1'b1;
        w_index_next = ONE;
        w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_data_ready) begin
          // index has wrapped to 0 once element N-1 sits in o_data
          if (r_index != '0) begin
            w_rd_en      = 1'b1;
            w_index_next = r_index + 1'b1;
          end else begin
            w_valid_next = 1'b0;
            w_state_next = S_LOAD;
          end
        end
      end
      default: begin
        w_state_next = S_LOAD;
      end
    endcase
    if (i_rst) begin
      w_state_next = S_LOAD;
      w_index_next = '0;
      w_valid_next = 1'b0;
      w_wr_en      = 1'b0;
      w_rd_en      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_LOAD;
      r_index <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
      r_valid <= w_valid_next;
      if (w_rd_en) r_data <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= i_data[DATA_W-1:0];
  end

  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign index        = r_index;
  assign indexNext    = w_index_next;

endmodule

// File: tb/tb_data_ctrl.sv
// Randomized bench for data_ctrl: a frame-level model predicts handshakes, index and drain order.
module tb_data_ctrl;

  localparam int DATA_W = 32;
  localparam int LOG2N  = 9;
  localparam int N      = 1 << LOG2N;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [DATA_W:0]   i_data = '0;
  logic              i_data_valid = 1'b0;
  logic              o_data_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              i_data_ready = 1'b0;
  logic [LOG2N-1:0]  index;
  logic [LOG2N-1:0]  indexNext;

  data_ctrl #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .index        (index),
    .indexNext    (indexNext)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: a frame being filled, then a queue of samples in drain order
  bit                m_loading = 1'b1;
  bit                m_gap     = 1'b0;
  int                m_wptr    = 0;
  logic [DATA_W-1:0] m_frame [N];
  logic [DATA_W-1:0] m_q [$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int addr_of(input int k);
    int r;
`ifdef DATACTRL_BITREV_EN
    r = 0;
    for (int b = 0; b < LOG2N; b++)
      if (((k >> b) & 1) != 0) r += 1 << (LOG2N - 1 - b);
`else
    r = k;
`endif
    return r;
  endfunction

  function automatic bit exp_valid();
    return !m_loading && !m_gap;
  endfunction

  function automatic int exp_index();
    if (m_loading) return m_wptr;
    if (m_gap) return 0;
    return (N - m_q.size() + 1) % N;
  endfunction

  task automatic model_reset();
    m_loading = 1'b1;
    m_gap     = 1'b0;
    m_wptr    = 0;
    m_q.delete();
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    i_data_valid = 1'b0;
    i_data_ready = 1'b0;
    #1;
    check_eq("rst_ready", o_data_ready, 0);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      check_eq("rst_valid", o_data_valid, 0);
      check_eq("rst_data", o_data, 0);
      check_eq("rst_index", index, 0);
      check_eq("rst_indexNext", indexNext, 0);
      check_eq("rst_ready", o_data_ready, 0);
    end
    i_rst = 1'b0;
    model_reset();
    #1;
    check_eq("post_rst_ready", o_data_ready, 1);
  endtask

  // called just after a rising edge; checks outputs, drives one cycle, updates the model
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic f, input logic r);
    logic [LOG2N-1:0] nxt;
    bit acc, hs;
    check_eq("ready", o_data_ready, m_loading);
    check_eq("valid", o_data_valid, exp_valid());
    check_eq("index", index, exp_index());
    if (exp_valid()) check_eq("data", o_data, m_q[0]);
    i_data_valid = v;
    i_data       = {f, d};
    i_data_ready = r;
    acc = v && m_loading;
    hs  = r && exp_valid();
    @(negedge i_clk);
    nxt = indexNext;
    @(posedge i_clk);
    if (m_loading) begin
      if (acc) begin
        if (f) begin
          m_frame[0] = d;
          m_wptr = 1;
        end else begin
          m_frame[m_wptr] = d;
          m_wptr++;
          if (m_wptr == N) begin
            m_loading = 1'b0;
            m_gap = 1'b1;
            m_q.delete();
            for (int k = 0; k < N; k++) m_q.push_back(m_frame[addr_of(k)]);
          end
        end
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (hs) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_loading = 1'b1;
        m_wptr = 0;
      end
    end
    #1;
    check_eq("indexNext", nxt, exp_index());
  endtask

  task automatic drain(input int mode, input int budget);
    int c = 0;
    while (!m_loading && c < budget) begin
      cycle(1'b0, '0, 1'b0, (mode == 0) ? 1'b1 : logic'(c % 2));
      c++;
    end
    check_eq("drain_done", o_data_ready, 1);
  endtask

  initial begin
    do_reset(5);

    // sequential frame, downstream always ready
    for (int k = 0; k < N; k++) cycle(1'b1, DATA_W'(k), 1'b0, 1'b0);
    drain(0, 2 * N);

    // random data, ready toggling every other cycle
    for (int k = 0; k < N; k++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    drain(1, 4 * N);

    // resync flag at index 100, then 511 more accepts complete the frame
    for (int k = 0; k < 100; k++) cycle(1'b1, DATA_W'(k + 1000), 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_AAAA, 1'b1, 1'b0);
    for (int k = 0; k < N - 1; k++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    check_eq("flag_frame_done", o_data_ready, 0);
    drain(0, 2 * N);

    // fully random traffic with rare resync flags
    for (int c = 0; c < 9000; c++)
      cycle(logic'($urandom_range(0, 1)), $urandom, logic'($urandom_range(0, 199) == 0),
            logic'($urandom_range(0, 1)));

    // abandon a frame mid-drain with reset, then one clean frame
    while (m_loading) cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) cycle(1'b0, '0, 1'b0, logic'($urandom_range(0, 1)));
    @(negedge i_clk);
    do_reset(3);
    @(posedge i_clk);
    #1;
    for (int k = 0; k < N; k++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    drain(0, 2 * N);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
